// File: rtl/image_capture_sequencer.sv
// Capture datapath sequencer: zero-fills frame memory on request, arms on vsync,
// streams pixels into memory, counts frames and reports done/overrun.
module image_capture_sequencer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MEM_DEPTH  = 1024,
  parameter  int FCNT_WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  capture_enable,
  input  logic                  clear_request,
  input  logic [FCNT_WIDTH-1:0] frame_count,
  input  logic                  vsync,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  capture_active,
  output logic                  clear_done,
  output logic                  done,
  output logic                  overrun,
  output logic [FCNT_WIDTH-1:0] frames_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  // One extra address bit so a full frame memory is distinguishable from address 0.
  localparam logic [ADDR_WIDTH:0] ADDR_FULL = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     addr_q, addr_d;
  logic [FCNT_WIDTH-1:0]   target_q, target_d;
  logic [FCNT_WIDTH-1:0]   frames_q, frames_d;
  logic [FCNT_WIDTH-1:0]   frames_inc;
  logic                    overrun_q, overrun_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    clear_done_q, clear_done_d;
  logic                    done_q, done_d;

  assign frames_inc = (frames_q == '1) ? frames_q : frames_q + 1'b1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      target_q     <= '0;
      frames_q     <= '0;
      overrun_q    <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      clear_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      target_q     <= target_d;
      frames_q     <= frames_d;
      overrun_q    <= overrun_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      clear_done_q <= clear_done_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    target_d     = target_q;
    frames_d     = frames_q;
    overrun_d    = overrun_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    clear_done_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_request) begin
          // First zero write is issued on entry so CLEAR spans exactly MEM_DEPTH writes.
          state_d = S_CLEAR;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
          addr_d  = ADDR_ONE;
        end else if (capture_enable) begin
          state_d   = S_ARM;
          target_d  = frame_count;
          frames_d  = '0;
          overrun_d = 1'b0;
        end
      end

      S_CLEAR: begin
        if (addr_q == ADDR_FULL) begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
          addr_d       = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = addr_q[ADDR_WIDTH-1:0];
          wdata_d = '0;
          addr_d  = addr_q + ADDR_ONE;
        end
      end

      S_ARM: begin
        if (!capture_enable) begin
          state_d = S_IDLE;
        end else if (vsync) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
          if (pixel_valid) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = pixel_data;
            addr_d  = ADDR_ONE;
          end
        end
      end

      S_CAPTURE: begin
        if (!capture_enable) begin
          state_d = S_IDLE;
        end else if (vsync) begin
          frames_d = frames_inc;
          if ((target_q != '0) && (frames_inc == target_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d = '0;
            if (pixel_valid) begin
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = pixel_data;
              addr_d  = ADDR_ONE;
            end
          end
        end else if (pixel_valid) begin
          if (addr_q == ADDR_FULL) begin
            overrun_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q[ADDR_WIDTH-1:0];
            wdata_d = pixel_data;
            addr_d  = addr_q + ADDR_ONE;
          end
        end
      end

      S_DONE: begin
        if (!capture_enable) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we         = we_q;
  assign mem_addr       = waddr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = (state_q != S_IDLE);
  assign capture_active = (state_q == S_CAPTURE);
  assign clear_done     = clear_done_q;
  assign done           = done_q;
  assign overrun        = overrun_q;
  assign frames_done    = frames_q;

endmodule

// File: tb/tb_image_capture_sequencer.sv
// Self-checking bench for image_capture_sequencer: directed scenarios with fixed
// expectations, then randomized traffic against a queue/counter reference model.
module tb_image_capture_sequencer;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FW    = 8;

  logic          aclk = 1'b0;
  logic          areset, capture_enable, clear_request, vsync, pixel_valid;
  logic [FW-1:0] frame_count;
  logic [DW-1:0] pixel_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy, capture_active, clear_done, done, overrun;
  logic [FW-1:0] frames_done;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  image_capture_sequencer #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .FCNT_WIDTH(FW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .capture_enable(capture_enable),
    .clear_request (clear_request),
    .frame_count   (frame_count),
    .vsync         (vsync),
    .pixel_valid   (pixel_valid),
    .pixel_data    (pixel_data),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .capture_active(capture_active),
    .clear_done    (clear_done),
    .done          (done),
    .overrun       (overrun),
    .frames_done   (frames_done)
  );

  // Reference model: a pending zero-fill is a queue of addresses ending with a
  // -1 marker for clear_done; capture is tracked as pixel position and frame tally.
  int clr_q[$];
  bit m_armed, m_capturing, m_finished, m_ovr;
  int m_pos, m_frames, m_target;
  bit e_we, e_cd, e_done;
  int e_addr, e_data;

  function automatic bit m_busy();
    return m_armed || m_capturing || m_finished || (clr_q.size() != 0);
  endfunction

  function automatic void model_step();
    e_we = 0; e_cd = 0; e_done = 0;
    if (areset) begin
      clr_q.delete();
      m_armed = 0; m_capturing = 0; m_finished = 0; m_ovr = 0;
      m_pos = 0; m_frames = 0; m_target = 0;
      return;
    end
    if (clr_q.size() == 0) begin
      if (m_finished) begin
        if (!capture_enable) m_finished = 0;
      end else if (m_armed) begin
        if (!capture_enable) m_armed = 0;
        else if (vsync) begin
          m_armed = 0; m_capturing = 1; m_pos = 0;
          if (pixel_valid) begin e_we = 1; e_addr = 0; e_data = pixel_data; m_pos = 1; end
        end
      end else if (m_capturing) begin
        if (!capture_enable) m_capturing = 0;
        else if (vsync) begin
          m_frames = (m_frames >= 255) ? 255 : m_frames + 1;
          if (m_target != 0 && m_frames == m_target) begin
            m_capturing = 0; m_finished = 1; e_done = 1;
          end else begin
            m_pos = 0;
            if (pixel_valid) begin e_we = 1; e_addr = 0; e_data = pixel_data; m_pos = 1; end
          end
        end else if (pixel_valid) begin
          if (m_pos >= DEPTH) m_ovr = 1;
          else begin e_we = 1; e_addr = m_pos; e_data = pixel_data; m_pos++; end
        end
      end else if (clear_request) begin
        for (int a = 0; a < DEPTH; a++) clr_q.push_back(a);
        clr_q.push_back(-1);
      end else if (capture_enable) begin
        m_armed = 1; m_target = frame_count; m_frames = 0; m_ovr = 0;
      end
    end
    if (clr_q.size() != 0) begin
      automatic int a = clr_q.pop_front();
      if (a < 0) e_cd = 1;
      else begin e_we = 1; e_addr = a; e_data = 0; end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    capture_enable = 0; clear_request = 0; vsync = 0; pixel_valid = 0;
    pixel_data = '0; frame_count = '0;
  endtask

  task automatic test_reset();
    areset = 1; idle_inputs();
    tick(); tick();
    areset = 0;
    checks++;
    if ({mem_we, busy, capture_active, clear_done, done, overrun, frames_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b busy=%b act=%b cd=%b done=%b ovr=%b fd=%0d, want all 0",
               mem_we, busy, capture_active, clear_done, done, overrun, frames_done);
    end
  endtask

  task automatic test_clear();
    clear_request = 1; tick(); clear_request = 0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 8'h00 || clear_done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL clear_write[%0d]: got we=%b addr=%0d data=%h cd=%b busy=%b, want we=1 addr=%0d data=00 cd=0 busy=1",
                 i, mem_we, mem_addr, mem_wdata, clear_done, busy, i);
      end
      tick();
    end
    checks++;
    if (clear_done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_pulse: got cd=%b we=%b busy=%b, want cd=1 we=0 busy=0", clear_done, mem_we, busy);
    end
    tick();
    checks++;
    if (clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_width: got cd=%b, want 0", clear_done);
    end
  endtask

  task automatic test_frames();
    capture_enable = 1; frame_count = 8'd2; tick();
    checks++;
    if (busy !== 1'b1 || capture_active !== 1'b0 || frames_done !== 8'd0) begin
      errors++;
      $display("FAIL arm_state: got busy=%b act=%b fd=%0d, want busy=1 act=0 fd=0", busy, capture_active, frames_done);
    end
    vsync = 1; tick(); vsync = 0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) begin
        pixel_valid = 1; pixel_data = DW'((f == 0 ? 8'hA0 : 8'hB0) + p); tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(p) || mem_wdata !== DW'((f == 0 ? 8'hA0 : 8'hB0) + p) || capture_active !== 1'b1) begin
          errors++;
          $display("FAIL frame%0d_pixel%0d: got we=%b addr=%0d data=%h act=%b, want we=1 addr=%0d data=%h act=1",
                   f, p, mem_we, mem_addr, mem_wdata, capture_active, p, (f == 0 ? 8'hA0 : 8'hB0) + p);
        end
      end
      pixel_valid = 0; vsync = 1; tick(); vsync = 0;
      checks++;
      if (frames_done !== FW'(f + 1) || done !== (f == 1) || capture_active !== (f == 0)) begin
        errors++;
        $display("FAIL frame%0d_boundary: got fd=%0d done=%b act=%b, want fd=%0d done=%b act=%b",
                 f, frames_done, done, capture_active, f + 1, f == 1, f == 0);
      end
    end
    tick(); tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || frames_done !== 8'd2) begin
      errors++;
      $display("FAIL done_hold: got done=%b busy=%b fd=%0d, want done=0 busy=1 fd=2", done, busy, frames_done);
    end
    capture_enable = 0; tick();
    checks++;
    if (busy !== 1'b0 || frames_done !== 8'd2) begin
      errors++;
      $display("FAIL done_exit: got busy=%b fd=%0d, want busy=0 fd=2", busy, frames_done);
    end
  endtask

  task automatic test_overrun();
    capture_enable = 1; frame_count = 8'd0; tick();
    vsync = 1; tick(); vsync = 0;
    for (int p = 0; p <= DEPTH; p++) begin
      pixel_valid = 1; pixel_data = DW'(8'h10 + p); tick();
      checks++;
      if (p < DEPTH) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(p) || mem_wdata !== DW'(8'h10 + p) || overrun !== 1'b0) begin
          errors++;
          $display("FAIL fill_pixel%0d: got we=%b addr=%0d data=%h ovr=%b, want we=1 addr=%0d data=%h ovr=0",
                   p, mem_we, mem_addr, mem_wdata, overrun, p, 8'h10 + p);
        end
      end else if (mem_we !== 1'b0 || overrun !== 1'b1) begin
        errors++;
        $display("FAIL overrun_pixel: got we=%b ovr=%b, want we=0 ovr=1", mem_we, overrun);
      end
    end
    pixel_valid = 0; vsync = 1; tick(); vsync = 0;
    pixel_valid = 1; pixel_data = 8'h55; tick(); pixel_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h55 || overrun !== 1'b1 || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL overrun_restart: got we=%b addr=%0d data=%h ovr=%b fd=%0d, want we=1 addr=0 data=55 ovr=1 fd=1",
               mem_we, mem_addr, mem_wdata, overrun, frames_done);
    end
    capture_enable = 0; tick();
  endtask

  task automatic test_same_cycle();
    capture_enable = 1; frame_count = 8'd0; tick();
    vsync = 1; pixel_valid = 1; pixel_data = 8'h3C; tick();
    vsync = 0; pixel_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h3C || capture_active !== 1'b1) begin
      errors++;
      $display("FAIL arm_vsync_pixel: got we=%b addr=%0d data=%h act=%b, want we=1 addr=0 data=3c act=1",
               mem_we, mem_addr, mem_wdata, capture_active);
    end
    pixel_valid = 1; pixel_data = 8'h01; tick(); tick(); pixel_valid = 0;
    vsync = 1; pixel_valid = 1; pixel_data = 8'h5A; tick();
    vsync = 0; pixel_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h5A || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL capture_vsync_pixel: got we=%b addr=%0d data=%h fd=%0d, want we=1 addr=0 data=5a fd=1",
               mem_we, mem_addr, mem_wdata, frames_done);
    end
    capture_enable = 0; tick();
  endtask

  task automatic test_clear_priority();
    capture_enable = 1; clear_request = 1; frame_count = 8'd0; tick(); clear_request = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd0 || capture_active !== 1'b0) begin
      errors++;
      $display("FAIL prio_clear_first: got we=%b addr=%0d act=%b, want we=1 addr=0 act=0", mem_we, mem_addr, capture_active);
    end
    for (int i = 1; i <= DEPTH; i++) tick();
    checks++;
    if (clear_done !== 1'b1) begin
      errors++;
      $display("FAIL prio_clear_done: got cd=%b, want 1", clear_done);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || capture_active !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL prio_then_arm: got busy=%b act=%b we=%b, want busy=1 act=0 we=0", busy, capture_active, mem_we);
    end
    vsync = 1; tick(); vsync = 0;
    checks++;
    if (capture_active !== 1'b1) begin
      errors++;
      $display("FAIL prio_capture: got act=%b, want 1", capture_active);
    end
    capture_enable = 0; tick();
  endtask

  task automatic test_reset_mid_clear();
    bit seen_cd;
    clear_request = 1; tick(); clear_request = 0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd7) begin
      errors++;
      $display("FAIL midclear_addr: got we=%b addr=%0d, want we=1 addr=7", mem_we, mem_addr);
    end
    areset = 1; tick(); areset = 0;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL midclear_reset: got we=%b busy=%b cd=%b, want we=0 busy=0 cd=0", mem_we, busy, clear_done);
    end
    seen_cd = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      tick();
      if (clear_done === 1'b1 || mem_we === 1'b1) seen_cd = 1;
    end
    checks++;
    if (seen_cd) begin
      errors++;
      $display("FAIL midclear_aborted: got late clear activity=1, want 0");
    end
  endtask

  task automatic test_random();
    areset = 1; idle_inputs(); tick(); areset = 0;
    for (int c = 0; c < 4000; c++) begin
      areset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) capture_enable = ~capture_enable;
      clear_request = ($urandom_range(0, 59) == 0);
      frame_count   = FW'($urandom_range(0, 3));
      vsync         = ($urandom_range(0, 29) == 0);
      pixel_valid   = $urandom_range(0, 1);
      pixel_data    = DW'($urandom);
      tick();
      checks++;
      if (mem_we !== e_we || (e_we && (mem_addr !== AW'(e_addr) || mem_wdata !== DW'(e_data)))) begin
        errors++;
        $display("FAIL rand_write c=%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                 c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_data);
      end
      checks++;
      if (clear_done !== e_cd || done !== e_done || overrun !== m_ovr || frames_done !== FW'(m_frames)) begin
        errors++;
        $display("FAIL rand_status c=%0d: got cd=%b done=%b ovr=%b fd=%0d, want cd=%b done=%b ovr=%b fd=%0d",
                 c, clear_done, done, overrun, frames_done, e_cd, e_done, m_ovr, m_frames);
      end
      checks++;
      if (busy !== m_busy() || capture_active !== m_capturing) begin
        errors++;
        $display("FAIL rand_state c=%0d: got busy=%b act=%b, want busy=%b act=%b",
                 c, busy, capture_active, m_busy(), m_capturing);
      end
    end
  endtask

  initial begin
    areset = 1;
    idle_inputs();
    test_reset();
    test_clear();
    test_frames();
    test_overrun();
    test_same_cycle();
    test_clear_priority();
    test_reset_mid_clear();
    idle_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
